// File: rtl/usart_pkg.sv
// Shared definitions for the USART hex-dump path: ASCII constants, nibble
// formatting and the dump FSM state type.
package usart_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StColon,
    StRead,
    StWait,
    StSpace,
    StHi,
    StLo,
    StCr,
    StLf
  } dump_state_e;

  // Uppercase hex digit.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/usart_hex_dump_if.sv
// Memory read port and tx byte handshake of the hex dumper, bundled.
interface usart_hex_dump_if #(
  parameter int unsigned ADDR_WIDTH = 16
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic [7:0]            mem_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output mem_addr, mem_read, tx_data, tx_valid,
    input  mem_data, tx_ready
  );

  modport slave (
    input  mem_addr, mem_read, tx_data, tx_valid,
    output mem_data, tx_ready
  );

endinterface

// File: rtl/usart_tx_holder.sv
// Single-entry output register: once valid, data is held until the
// transmitter takes it; a new character may be loaded in the transfer cycle.
module usart_tx_holder (
  input  logic       comm_clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       can_load
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  assign can_load = !valid_q || tx_ready;
  assign tx_data  = data_q;
  assign tx_valid = valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load && can_load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (tx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/usart_hex_dump.sv
// Reads an inclusive address range from memory and streams it to the USART
// tx as "AAAA: DD DD ...\r\n" lines. Address formatting assumes 16-bit addresses.
module usart_hex_dump
  import usart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned BYTES_PER_LINE = 16
) (
  input  logic                  comm_clock,
  input  logic                  reset_n,
  input  logic                  dump_start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic                  busy,
  usart_hex_dump_if.master      bus
);

  localparam logic [ADDR_WIDTH-1:0] LineMask = ADDR_WIDTH'(BYTES_PER_LINE - 1);

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [1:0]            digit_q, digit_d;
  logic [7:0]            byte_q, byte_d;
  logic                  busy_q, busy_d;
  logic                  start_prev_q;

  logic       load;
  logic [7:0] load_char;
  logic       can_load;
  logic       tx_valid;
  logic       mem_read;
  logic [3:0] addr_nib;
  logic       last_slot;
  logic       at_end;

  assign last_slot = (addr_q & LineMask) == LineMask;
  assign at_end    = (addr_q == end_q);

  always_comb begin
    unique case (digit_q)
      2'd0:    addr_nib = addr_q[15:12];
      2'd1:    addr_nib = addr_q[11:8];
      2'd2:    addr_nib = addr_q[7:4];
      default: addr_nib = addr_q[3:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    end_d     = end_q;
    digit_d   = digit_q;
    byte_d    = byte_q;
    busy_d    = busy_q;
    load      = 1'b0;
    load_char = 8'h00;
    mem_read  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // busy lingers until the final LF has left the holder.
        if (busy_q) begin
          if (!tx_valid || bus.tx_ready) busy_d = 1'b0;
        end else if (dump_start && !start_prev_q) begin
          addr_d  = start_addr;
          end_d   = end_addr;
          digit_d = 2'd0;
          busy_d  = 1'b1;
          if (end_addr >= start_addr) state_d = StAddr;
        end
      end
      StAddr: begin
        load      = 1'b1;
        load_char = hex_to_ascii(addr_nib);
        if (can_load) begin
          digit_d = digit_q + 2'd1;
          if (digit_q == 2'd3) state_d = StColon;
        end
      end
      StColon: begin
        load      = 1'b1;
        load_char = ASCII_COLON;
        if (can_load) state_d = StRead;
      end
      StRead: begin
        if (can_load) begin
          mem_read = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        byte_d  = bus.mem_data;
        state_d = StSpace;
      end
      StSpace: begin
        load      = 1'b1;
        load_char = ASCII_SPACE;
        if (can_load) state_d = StHi;
      end
      StHi: begin
        load      = 1'b1;
        load_char = hex_to_ascii(byte_q[7:4]);
        if (can_load) state_d = StLo;
      end
      StLo: begin
        load      = 1'b1;
        load_char = hex_to_ascii(byte_q[3:0]);
        if (can_load) begin
          if (last_slot || at_end) begin
            state_d = StCr;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = StRead;
          end
        end
      end
      StCr: begin
        load      = 1'b1;
        load_char = ASCII_CR;
        if (can_load) state_d = StLf;
      end
      StLf: begin
        load      = 1'b1;
        load_char = ASCII_LF;
        if (can_load) begin
          // Stopping on equality keeps end_addr=0xFFFF from wrapping to 0.
          if (at_end) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            digit_d = 2'd0;
            state_d = StAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      end_q        <= '0;
      digit_q      <= 2'd0;
      byte_q       <= 8'h00;
      busy_q       <= 1'b0;
      start_prev_q <= dump_start;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      end_q        <= end_d;
      digit_q      <= digit_d;
      byte_q       <= byte_d;
      busy_q       <= busy_d;
      start_prev_q <= dump_start;
    end
  end

  usart_tx_holder u_tx_holder (
    .comm_clock (comm_clock),
    .reset_n    (reset_n),
    .load       (load),
    .load_data  (load_char),
    .tx_ready   (bus.tx_ready),
    .tx_data    (bus.tx_data),
    .tx_valid   (tx_valid),
    .can_load   (can_load)
  );

  assign bus.tx_valid = tx_valid;
  assign bus.mem_addr = addr_q;
  assign bus.mem_read = mem_read;
  assign busy         = busy_q;

endmodule

// File: tb/tb_usart_hex_dump.sv
// Scoreboard bench for usart_hex_dump: expected characters are queued by the
// stimulus and popped by an independent monitor on every tx transfer.
module tb_usart_hex_dump;

  logic        clk;
  logic        reset_n;
  logic        dump_start;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic        busy;

  usart_hex_dump_if #(.ADDR_WIDTH(16)) bus ();

  usart_hex_dump #(
    .ADDR_WIDTH     (16),
    .BYTES_PER_LINE (16)
  ) dut (
    .comm_clock (clk),
    .reset_n    (reset_n),
    .dump_start (dump_start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .busy       (busy),
    .bus        (bus)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] exp_q [$];
  int         vectors;
  int         miscompares;
  int         mem_reads;
  int         busy_cycles;
  int         ready_mode;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Synchronous memory: data appears one cycle after the read strobe.
  initial bus.mem_data = 8'h00;
  always @(posedge clk) if (bus.mem_read) bus.mem_data <= mem[bus.mem_addr];

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = ($urandom_range(0, 9) < 3);
        default: bus.tx_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  task automatic run_dump(input string name, input logic [15:0] s, input logic [15:0] e,
                          input int reads);
    mem_reads   = 0;
    busy_cycles = 0;
    tick();
    start_addr = s;
    end_addr   = e;
    dump_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_busy_rise"}, 32'(busy), 32'd1);
    tick();
    dump_start = 1'b0;
    wait_idle(name);
    check({name, "_stream_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_mem_reads"}, 32'(mem_reads), 32'(reads));
  endtask

  // Monitor: pops on transfers, checks hold stability, counts strobes.
  initial begin
    logic       pend;
    logic [7:0] pend_data;
    logic [7:0] e;
    pend = 1'b0;
    pend_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (busy) busy_cycles++;
        if (bus.mem_read) mem_reads++;
        if (pend) check("tx_hold", 32'({bus.tx_valid, bus.tx_data}), 32'({1'b1, pend_data}));
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_extra: got %h expected no character", bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_char", 32'(bus.tx_data), 32'(e));
          end
        end
        pend      = bus.tx_valid && !bus.tx_ready;
        pend_data = bus.tx_data;
      end
    end
  end

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    mem_reads   = 0;
    busy_cycles = 0;
    ready_mode  = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) mem[i] = 8'(8'h10 + i);
    mem[16'hFFFF] = 8'hAB;

    reset_n    = 1'b0;
    dump_start = 1'b0;
    start_addr = 16'h0000;
    end_addr   = 16'h0000;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);

    push_line("0000: 10 11 12 13");
    run_dump("basic", 16'h0000, 16'h0003, 4);

    push_line("000E: 1E 1F");
    push_line("0010: 20 21");
    run_dump("split", 16'h000E, 16'h0011, 4);

    ready_mode = 1;
    push_line("0000: 10 11 12 13");
    run_dump("backpressure", 16'h0000, 16'h0003, 4);
    ready_mode = 0;

    run_dump("empty", 16'h0005, 16'h0004, 0);
    check("empty_busy_cycles", 32'(busy_cycles), 32'd1);

    push_line("FFFF: AB");
    run_dump("top", 16'hFFFF, 16'hFFFF, 1);
    busy_cycles = 0;
    repeat (20) @(negedge clk);
    check("top_no_wrap_busy", 32'(busy_cycles), 32'd0);
    check("top_no_wrap_reads", 32'(mem_reads), 32'd1);

    // Second rising edge while busy must be ignored.
    mem_reads = 0;
    push_line("0000: 10 11 12 13");
    tick();
    start_addr = 16'h0000;
    end_addr   = 16'h0003;
    dump_start = 1'b1;
    repeat (3) tick();
    dump_start = 1'b0;
    repeat (2) tick();
    start_addr = 16'h0010;
    end_addr   = 16'h0011;
    dump_start = 1'b1;
    repeat (2) tick();
    dump_start = 1'b0;
    wait_idle("reedge");
    check("reedge_stream_left", 32'(exp_q.size()), 32'd0);
    check("reedge_mem_reads", 32'(mem_reads), 32'd4);
    busy_cycles = 0;
    repeat (10) @(negedge clk);
    check("reedge_quiet", 32'(busy_cycles), 32'd0);

    // Level held high across reset release must not start a dump.
    tick();
    dump_start = 1'b1;
    reset_n    = 1'b0;
    repeat (2) tick();
    reset_n     = 1'b1;
    busy_cycles = 0;
    mem_reads   = 0;
    repeat (10) tick();
    check("held_start_busy", 32'(busy_cycles), 32'd0);
    check("held_start_reads", 32'(mem_reads), 32'd0);
    dump_start = 1'b0;

    // Reset while a character is pending.
    ready_mode = 2;
    repeat (2) tick();
    start_addr = 16'h0000;
    end_addr   = 16'h0003;
    dump_start = 1'b1;
    n = 0;
    while (!bus.tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_valid_seen", 32'(bus.tx_valid), 32'd1);
    tick();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_read", 32'(bus.mem_read), 32'd0);
    dump_start = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    ready_mode = 1;
    push_line("0014: 24 25 26");
    run_dump("after_abort", 16'h0014, 16'h0016, 3);

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
